e64_onehot_encoder: RTL and testbench

//  Reverse direction of the e64 one-hot priority decoder. Accepts a 65-line
//  one-hot grant vector and returns its 7-bit index through a 2-stage

---
 rtl/e64_onehot_encoder_pkg.sv | 17 +
 rtl/e64_onehot_encoder_if.sv | 26 ++
 rtl/e64_onehot_encoder_tree.sv | 43 ++++
 rtl/e64_onehot_encoder.sv | 89 ++++++++
 tb/tb_e64_onehot_encoder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/e64_onehot_encoder_pkg.sv
// Shared types and sizes for the e64 one-hot encoder: index width, error code
// and counter width.
package e64_pkg;

    localparam int N    = 65;
    localparam int IDXW = 7;
    localparam int CNTW = 16;

    typedef logic [IDXW-1:0] idx_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_ZERO  = 2'b01,
        ERR_MULTI = 2'b10
    } err_t;

endpackage

// File: rtl/e64_onehot_encoder_if.sv
// Input/output stream bundle of the e64 one-hot encoder, including the error
// counter and its clear.
interface e64_onehot_encoder_if;
    import e64_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             out_valid;
    logic             out_ready;
    idx_t             out_idx;
    err_t             out_err;
    logic [CNTW-1:0]  err_cnt;
    logic             err_clr;

    modport master (
        output in_valid, in_vec, out_ready, err_clr,
        input  in_ready, out_valid, out_idx, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_vec, out_ready, err_clr,
        output in_ready, out_valid, out_idx, out_err, err_cnt
    );

endinterface

// File: rtl/e64_onehot_encoder_tree.sv
// Combinational log-depth priority tree: lowest set index of an N-bit vector
// plus zero-hot and multi-hot flags.
module e64_onehot_tree
    import e64_pkg::*;
(
    input  logic [N-1:0] vec_i,
    output idx_t         idx_o,
    output logic         zero_o,
    output logic         multi_o
);

    localparam int LEAVES = 1 << IDXW;

    // Each level pairs adjacent nodes; the lower half wins, the upper half
    // contributes its index with this level's bit set.
    for (genvar l = 0; l <= IDXW; l++) begin : lvl
        localparam int NN = LEAVES >> l;
        logic [NN-1:0] hit;
        logic [NN-1:0] mult;
        idx_t          pos [NN];

        if (l == 0) begin : g_leaf
            assign hit  = {{(LEAVES-N){1'b0}}, vec_i};
            assign mult = '0;
            for (genvar i = 0; i < NN; i++) begin : g_pos
                assign pos[i] = '0;
            end
        end else begin : g_merge
            for (genvar i = 0; i < NN; i++) begin : g_node
                assign hit[i]  = lvl[l-1].hit[2*i] | lvl[l-1].hit[2*i+1];
                assign mult[i] = lvl[l-1].mult[2*i] | lvl[l-1].mult[2*i+1]
                               | (lvl[l-1].hit[2*i] & lvl[l-1].hit[2*i+1]);
                assign pos[i]  = lvl[l-1].hit[2*i] ? lvl[l-1].pos[2*i]
                               : (lvl[l-1].pos[2*i+1] | idx_t'(1 << (l-1)));
            end
        end
    end

    assign zero_o  = ~lvl[IDXW].hit[0];
    assign multi_o = lvl[IDXW].mult[0];
    assign idx_o   = lvl[IDXW].hit[0] ? lvl[IDXW].pos[0] : '0;

endmodule

// File: rtl/e64_onehot_encoder.sv
// Two-stage valid/ready one-hot to index encoder with malformed-vector
// detection and a saturating error counter.
module e64_onehot_encoder
    import e64_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    e64_onehot_encoder_if.slave bus
);

    logic [N-1:0]    vec_p1;
    logic            vld_p1;
    logic            vld_p2;
    idx_t            idx_p2;
    err_t            err_p2;
    logic [CNTW-1:0] err_cnt_q;

    idx_t idx_c;
    logic zero_c;
    logic multi_c;
    err_t err_c;

    logic s2_load;
    logic in_fire;
    logic out_fire;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    assign s2_load  = vld_p1 && (!vld_p2 || bus.out_ready);
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = vld_p2 && bus.out_ready;

    assign bus.in_ready  = !vld_p1 || s2_load;
    assign bus.out_valid = vld_p2;
    assign bus.out_idx   = idx_p2;
    assign bus.out_err   = err_p2;
    assign bus.err_cnt   = err_cnt_q;

    // Stage 1: capture the raw vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vec_p1 <= '0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
            vec_p1 <= bus.in_vec;
        end else if (s2_load) begin
            vld_p1 <= 1'b0;
        end
    end

    e64_onehot_tree u_tree (
        .vec_i   (vec_p1),
        .idx_o   (idx_c),
        .zero_o  (zero_c),
        .multi_o (multi_c)
    );

    assign err_c = zero_c ? ERR_ZERO : (multi_c ? ERR_MULTI : ERR_OK);

    // Stage 2: encoded index and error code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            idx_p2 <= '0;
            err_p2 <= ERR_OK;
        end else if (s2_load) begin
            vld_p2 <= 1'b1;
            idx_p2 <= idx_c;
            err_p2 <= err_c;
        end else if (out_fire) begin
            vld_p2 <= 1'b0;
        end
    end

    // Clear wins over a same-cycle malformed handoff, which is then not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            err_cnt_q <= '0;
        end else if (out_fire && (err_p2 != ERR_OK)) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

endmodule

// File: tb/tb_e64_onehot_encoder.sv
// Directed bench for e64_onehot_encoder: encoding, streaming, backpressure,
// counter saturation/clear and mid-flight reset.
module tb_e64_onehot_encoder;
    import e64_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_res;
    int   exp_i;
    int   first_c;
    int   last_c;

    e64_onehot_encoder_if bus ();

    e64_onehot_encoder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] bit_vec(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Offer one vector with out_ready=1, check it two cycles later, then hand it off.
    task automatic send_one(input string tag, input logic [N-1:0] v,
                            input int exp_idx, input err_t exp_err);
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_idx"},   64'(bus.out_idx),   64'(exp_idx));
        chk({tag, "_err"},   64'(bus.out_err),   64'(exp_err));
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_idx",   64'(bus.out_idx),   64'd0);
        chk("rst_out_err",   64'(bus.out_err),   64'd0);
        chk("rst_err_cnt",   64'(bus.err_cnt),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single well-formed, zero-hot, multi-hot and top-bit vectors
        send_one("t1", bit_vec(37), 37, ERR_OK);
        chk("t1_cnt", 64'(bus.err_cnt), 64'd0);
        send_one("t2", '0, 0, ERR_ZERO);
        chk("t2_cnt", 64'(bus.err_cnt), 64'd1);
        send_one("t3_multi", bit_vec(5) | bit_vec(64), 5, ERR_MULTI);
        chk("t3_cnt", 64'(bus.err_cnt), 64'd2);
        send_one("t3_top", bit_vec(64), 64, ERR_OK);
        chk("t3_after_valid", 64'(bus.out_valid), 64'd0);

        // Back-to-back stream of every index
        n_res = 0;
        exp_i = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 70; c++) begin
            if (c < 65) begin
                bus.in_vec   = bit_vec(c);
                bus.in_valid = 1'b1;
                chk("t4_in_ready", 64'(bus.in_ready), 64'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (bus.out_valid) begin
                chk("t4_idx", 64'(bus.out_idx), 64'(exp_i));
                chk("t4_err", 64'(bus.out_err), 64'(ERR_OK));
                if (first_c < 0) first_c = c;
                last_c = c;
                exp_i++;
                n_res++;
            end
        end
        chk("t4_count", 64'(n_res), 64'd65);
        chk("t4_span",  64'(last_c - first_c), 64'd64);

        // Backpressure: two entries fit, the third waits
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_vec    = bit_vec(1);
        chk("t5_rdy1", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_vec = bit_vec(2);
        chk("t5_rdy2", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_vec = bit_vec(3);
        chk("t5_rdy3", 64'(bus.in_ready), 64'd0);
        step();
        step();
        chk("t5_hold_rdy",   64'(bus.in_ready),  64'd0);
        chk("t5_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_hold_idx",   64'(bus.out_idx),   64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("t5_rdy_comb", 64'(bus.in_ready), 64'd1);
        chk("t5_out1",     64'(bus.out_idx),  64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("t5_out2", 64'(bus.out_idx), 64'd2);
        step();
        chk("t5_out3", 64'(bus.out_idx), 64'd3);
        step();
        chk("t5_drained", 64'(bus.out_valid), 64'd0);

        // Counter saturation and clear priority
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t6_clr", 64'(bus.err_cnt), 64'd0);
        bus.in_vec   = '0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 65534; k++) step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        chk("t6_fffe", 64'(bus.err_cnt), 64'hFFFE);
        bus.in_valid = 1'b1;
        step();
        step();
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        chk("t6_sat", 64'(bus.err_cnt), 64'hFFFF);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("t6_pending_err", 64'(bus.out_err), 64'(ERR_ZERO));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t6_clr_prio", 64'(bus.err_cnt), 64'd0);
        chk("t6_handed",   64'(bus.out_valid), 64'd0);

        // Reset with two entries in flight
        send_one("t7_pre", '0, 0, ERR_ZERO);
        chk("t7_cnt_pre", 64'(bus.err_cnt), 64'd1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_vec    = bit_vec(10);
        step();
        bus.in_vec = bit_vec(11);
        step();
        bus.in_valid = 1'b0;
        chk("t7_full", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t7_rst_ready", 64'(bus.in_ready),  64'd1);
        chk("t7_rst_cnt",   64'(bus.err_cnt),   64'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("t7_no_stale1", 64'(bus.out_valid), 64'd0);
        step();
        chk("t7_no_stale2", 64'(bus.out_valid), 64'd0);
        send_one("t7_new", bit_vec(20), 20, ERR_OK);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
